// File: rtl/alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver
//
// Command-side front end for the 4-bit combinational ALU. Commands arrive
// over a valid/ready handshake and are registered onto the alu_* outputs.
// The ALU result is captured one cycle later and returned, together with
// the command tag, through an in-order response FIFO that has its own
// valid/ready handshake.
//
// Optional build macro: ALU_CMD_DRIVER_CHECK_EN
//   defined   : every captured result is compared against a built-in golden
//               model; mismatches are flagged per entry (rsp_err) and
//               counted (err_cnt, saturating at 8'hFF).
//   undefined : no golden model; rsp_err = 0, err_cnt = 8'h00. Datapath
//               timing is identical in both builds.
//
// Parameters
//   DEPTH       response FIFO entries (power of 2, >= 2)
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready       command handshake
//   cmd_op1, cmd_op2            4-bit operands
//   cmd_sel, cmd_c_in, cmd_mode operation select, carry in, mode
//   cmd_tag                     4-bit opaque ID returned with the response
//   alu_op1 .. alu_mode         registered drive into the ALU
//   alu_result                  8-bit ALU result
//   rsp_valid / rsp_ready       response handshake (FIFO head)
//   rsp_result, rsp_tag         captured result and its command tag
//   rsp_err                     golden-model mismatch for the head entry
//   err_cnt                     saturating mismatch count
//   busy                        command in flight or FIFO non-empty
//
// FSM
//   state | meaning
//   IDLE  | waiting for a command; alu_* hold the last command
//   EXEC  | ALU evaluating; result pushed into FIFO at the closing edge
// ---------------------------------------------------------------------------

package Types;
   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      MUL = 2'd2
   } sel_t;

   typedef enum logic [0:0] {
      MODE_ARITH = 1'b0,
      MODE_LOGIC = 1'b1
   } mode_t;
endpackage

module alu_cmd_driver
   import Types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,

   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op1,
   input  logic [3:0] cmd_op2,
   input  sel_t       cmd_sel,
   input  logic       cmd_c_in,
   input  mode_t      cmd_mode,
   input  logic [3:0] cmd_tag,

   output logic [3:0] alu_op1,
   output logic [3:0] alu_op2,
   output sel_t       alu_sel,
   output logic       alu_c_in,
   output mode_t      alu_mode,
   input  logic [7:0] alu_result,

   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_result,
   output logic [3:0] rsp_tag,
   output logic       rsp_err,
   output logic [7:0] err_cnt,
   output logic       busy
);

   localparam int              PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   state_t     state_q, state_d;

   logic [3:0] alu_op1_q,  alu_op1_d;
   logic [3:0] alu_op2_q,  alu_op2_d;
   sel_t       alu_sel_q,  alu_sel_d;
   logic       alu_c_in_q, alu_c_in_d;
   mode_t      alu_mode_q, alu_mode_d;
   logic [3:0] tag_q,      tag_d;

   logic [7:0] res_mem_q [DEPTH];
   logic [7:0] res_mem_d [DEPTH];
   logic [3:0] tag_mem_q [DEPTH];
   logic [3:0] tag_mem_d [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q,  count_d;

   logic push;
   logic pop;

   // ------------------------------------------------------------------
   // Command FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      alu_op1_d  = alu_op1_q;
      alu_op2_d  = alu_op2_q;
      alu_sel_d  = alu_sel_q;
      alu_c_in_d = alu_c_in_q;
      alu_mode_d = alu_mode_q;
      tag_d      = tag_q;
      cmd_ready  = 1'b0;
      push       = 1'b0;

      case (state_q)
         IDLE: begin
            // A free slot now guarantees room for the push one cycle later,
            // so the FIFO can never overflow.
            cmd_ready = (count_q != FULL_CNT);
            if (cmd_valid && cmd_ready) begin
               alu_op1_d  = cmd_op1;
               alu_op2_d  = cmd_op2;
               alu_sel_d  = cmd_sel;
               alu_c_in_d = cmd_c_in;
               alu_mode_d = cmd_mode;
               tag_d      = cmd_tag;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            push    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         alu_op1_q  <= 4'h0;
         alu_op2_q  <= 4'h0;
         alu_sel_q  <= ADD;
         alu_c_in_q <= 1'b0;
         alu_mode_q <= mode_t'(1'b0);
         tag_q      <= 4'h0;
      end else begin
         state_q    <= state_d;
         alu_op1_q  <= alu_op1_d;
         alu_op2_q  <= alu_op2_d;
         alu_sel_q  <= alu_sel_d;
         alu_c_in_q <= alu_c_in_d;
         alu_mode_q <= alu_mode_d;
         tag_q      <= tag_d;
      end
   end

   assign alu_op1  = alu_op1_q;
   assign alu_op2  = alu_op2_q;
   assign alu_sel  = alu_sel_q;
   assign alu_c_in = alu_c_in_q;
   assign alu_mode = alu_mode_q;

   // ------------------------------------------------------------------
   // Response FIFO
   // ------------------------------------------------------------------
   assign rsp_valid  = (count_q != '0);
   assign pop        = rsp_valid && rsp_ready;
   assign rsp_result = res_mem_q[rd_ptr_q];
   assign rsp_tag    = tag_mem_q[rd_ptr_q];
   assign busy       = (state_q == EXEC) || (count_q != '0);

   always_comb begin
      res_mem_d = res_mem_q;
      tag_mem_d = tag_mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;

      if (push) begin
         res_mem_d[wr_ptr_q] = alu_result;
         tag_mem_d[wr_ptr_q] = tag_q;
         wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_mem_q <= '{default: '0};
         tag_mem_q <= '{default: '0};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         res_mem_q <= res_mem_d;
         tag_mem_q <= tag_mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // ------------------------------------------------------------------
   // Golden-model self-check
   // ------------------------------------------------------------------
`ifdef ALU_CMD_DRIVER_CHECK_EN
   logic [7:0] golden;
   logic       mismatch;
   logic       err_mem_q [DEPTH];
   logic       err_mem_d [DEPTH];
   logic [7:0] err_cnt_q, err_cnt_d;

   // Operands are zero-extended to 8 bits; C_In and Mode are ignored.
   always_comb begin
      golden = 8'h00;
      case (alu_sel_q)
         ADD:     golden = {4'h0, alu_op1_q} + {4'h0, alu_op2_q};
         SUB:     golden = {4'h0, alu_op1_q} - {4'h0, alu_op2_q};
         MUL:     golden = {4'h0, alu_op1_q} * {4'h0, alu_op2_q};
         default: golden = 8'h00;
      endcase
   end

   assign mismatch = (alu_result != golden);

   always_comb begin
      err_mem_d = err_mem_q;
      err_cnt_d = err_cnt_q;
      if (push) begin
         err_mem_d[wr_ptr_q] = mismatch;
         if (mismatch && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'h01;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_mem_q <= '{default: 1'b0};
         err_cnt_q <= 8'h00;
      end else begin
         err_mem_q <= err_mem_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign rsp_err = err_mem_q[rd_ptr_q];
   assign err_cnt = err_cnt_q;
`else
   assign rsp_err = 1'b0;
   assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_driver
//
// Directed bench for alu_cmd_driver. A stub ALU computes the result from the
// DUT's alu_* drive (optionally forced to zero). A cycle-level reference
// model tracks accepted commands, the in-flight command and a queue of
// expected responses; it is compared with the DUT on every falling edge.
// Directed scenarios add literal expectations taken from hand calculation.
// ---------------------------------------------------------------------------

module tb_alu_cmd_driver;
   import Types::*;

   localparam int DEPTH = 4;

`ifdef ALU_CMD_DRIVER_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_op1 = 4'h0;
   logic [3:0] cmd_op2 = 4'h0;
   sel_t       cmd_sel = ADD;
   logic       cmd_c_in = 1'b0;
   mode_t      cmd_mode = MODE_ARITH;
   logic [3:0] cmd_tag = 4'h0;
   logic [3:0] alu_op1;
   logic [3:0] alu_op2;
   sel_t       alu_sel;
   logic       alu_c_in;
   mode_t      alu_mode;
   logic [7:0] alu_result;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_result;
   logic [3:0] rsp_tag;
   logic       rsp_err;
   logic [7:0] err_cnt;
   logic       busy;

   logic       force_zero = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_cmd_driver #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op1    (cmd_op1),
      .cmd_op2    (cmd_op2),
      .cmd_sel    (cmd_sel),
      .cmd_c_in   (cmd_c_in),
      .cmd_mode   (cmd_mode),
      .cmd_tag    (cmd_tag),
      .alu_op1    (alu_op1),
      .alu_op2    (alu_op2),
      .alu_sel    (alu_sel),
      .alu_c_in   (alu_c_in),
      .alu_mode   (alu_mode),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_tag    (rsp_tag),
      .rsp_err    (rsp_err),
      .err_cnt    (err_cnt),
      .busy       (busy)
   );

   // Expected ALU value from plain integer arithmetic.
   function automatic logic [7:0] gold(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] s);
      int r;
      case (s)
         2'd0:    r = int'(a) + int'(b);
         2'd1:    r = int'(a) - int'(b) + 256;
         2'd2:    r = int'(a) * int'(b);
         default: r = 0;
      endcase
      return 8'(r % 256);
   endfunction

   assign alu_result = force_zero ? 8'h00 : gold(alu_op1, alu_op2, alu_sel);

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   typedef struct {
      logic [3:0] op1;
      logic [3:0] op2;
      logic [1:0] sel;
      logic       c_in;
      logic       mode;
      logic [3:0] tag;
   } cmd_t;

   typedef struct {
      logic [7:0] result;
      logic [3:0] tag;
      logic       err;
   } rsp_t;

   cmd_t       m_alu;
   cmd_t       m_exec_cmd;
   bit         m_exec = 1'b0;
   rsp_t       m_q[$];
   int         m_err_cnt = 0;
   bit         m_acc = 1'b0;
   logic [3:0] got_tags[$];

   task automatic model_reset();
      m_exec  = 1'b0;
      m_q.delete();
      m_err_cnt = 0;
      m_acc   = 1'b0;
      m_alu   = '{op1: 4'h0, op2: 4'h0, sel: 2'd0, c_in: 1'b0, mode: 1'b0, tag: 4'h0};
   endtask

   initial model_reset();

   always @(negedge clk) begin
      bit   exp_ready;
      bit   do_pop;
      rsp_t e;
      logic [7:0] g;

      if (!rst_n) model_reset();

      exp_ready = !m_exec && (m_q.size() < DEPTH);
      check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(m_q.size() != 0));
      check("busy",      32'(busy),      32'(m_exec || (m_q.size() != 0)));
      check("err_cnt",   32'(err_cnt),   32'(m_err_cnt));
      check("alu_op1",   32'(alu_op1),   32'(m_alu.op1));
      check("alu_op2",   32'(alu_op2),   32'(m_alu.op2));
      check("alu_sel",   32'(alu_sel),   32'(m_alu.sel));
      check("alu_c_in",  32'(alu_c_in),  32'(m_alu.c_in));
      check("alu_mode",  32'(alu_mode),  32'(m_alu.mode));
      if (m_q.size() != 0) begin
         check("rsp_result", 32'(rsp_result), 32'(m_q[0].result));
         check("rsp_tag",    32'(rsp_tag),    32'(m_q[0].tag));
         check("rsp_err",    32'(rsp_err),    32'(m_q[0].err));
      end

      m_acc = 1'b0;
      if (rst_n) begin
         do_pop = (m_q.size() != 0) && rsp_ready;
         if (do_pop) begin
            got_tags.push_back(rsp_tag);
            void'(m_q.pop_front());
         end
         if (m_exec) begin
            g        = gold(m_exec_cmd.op1, m_exec_cmd.op2, m_exec_cmd.sel);
            e.result = force_zero ? 8'h00 : g;
            e.tag    = m_exec_cmd.tag;
            e.err    = CHK && (e.result != g);
            if (e.err && m_err_cnt < 255) m_err_cnt++;
            m_q.push_back(e);
            m_exec = 1'b0;
         end
         if (exp_ready && cmd_valid) begin
            m_acc      = 1'b1;
            m_exec     = 1'b1;
            m_exec_cmd = '{op1: cmd_op1, op2: cmd_op2, sel: cmd_sel,
                           c_in: cmd_c_in, mode: cmd_mode, tag: cmd_tag};
            m_alu      = m_exec_cmd;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (called at posedge + 1)
   // ------------------------------------------------------------------
   task automatic drive_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                            input logic ci, input logic md, input logic [3:0] t);
      cmd_op1   = a;
      cmd_op2   = b;
      cmd_sel   = sel_t'(s);
      cmd_c_in  = ci;
      cmd_mode  = mode_t'(md);
      cmd_tag   = t;
      cmd_valid = 1'b1;
   endtask

   // Returns at acceptance edge + 1.
   task automatic wait_acc();
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         if (m_acc) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      if (!ok) check("accept_timeout", 32'(0), 32'(1));
   endtask

   task automatic wait_tags(input int n);
      for (int i = 0; i < 60 && got_tags.size() < n; i++) @(posedge clk);
      #1;
      check("drain_count", 32'(got_tags.size()), 32'(n));
   endtask

   task automatic run_one(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                          input logic ci, input logic md, input logic [3:0] t,
                          input logic [7:0] exp_res, input logic exp_err,
                          input logic [7:0] exp_cnt);
      drive_cmd(a, b, s, ci, md, t);
      wait_acc();
      cmd_valid = 1'b0;
      check("lit_alu_op1", 32'(alu_op1), 32'(a));
      check("lit_alu_sel", 32'(alu_sel), 32'(s));
      check("lit_rsp_valid_early", 32'(rsp_valid), 32'(0));
      @(posedge clk); #1;
      check("lit_rsp_valid", 32'(rsp_valid),  32'(1));
      check("lit_rsp_result", 32'(rsp_result), 32'(exp_res));
      check("lit_rsp_tag",   32'(rsp_tag),    32'(t));
      check("lit_rsp_err",   32'(rsp_err),    32'(exp_err));
      check("lit_err_cnt",   32'(err_cnt),    32'(exp_cnt));
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------
   // Directed scenarios
   // ------------------------------------------------------------------
   initial begin
      logic [3:0] exp_tags[$];

      repeat (2) @(posedge clk);
      #1;
      check("lit_reset_rsp_valid", 32'(rsp_valid), 32'(0));
      check("lit_reset_busy",      32'(busy),      32'(0));
      check("lit_reset_alu_sel",   32'(alu_sel),   32'(ADD));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic operations, consumer always ready.
      rsp_ready = 1'b1;
      run_one(4'd9,  4'd7,  2'd0, 1'b0, 1'b0, 4'd3, 8'h10, 1'b0, 8'h00);
      run_one(4'd3,  4'd5,  2'd1, 1'b0, 1'b0, 4'd4, 8'hFE, 1'b0, 8'h00);
      run_one(4'd15, 4'd15, 2'd2, 1'b0, 1'b0, 4'd5, 8'hE1, 1'b0, 8'h00);
      run_one(4'd6,  4'd2,  2'd3, 1'b0, 1'b0, 4'd6, 8'h00, 1'b0, 8'h00);
      run_one(4'd9,  4'd7,  2'd0, 1'b1, 1'b1, 4'd7, 8'h10, 1'b0, 8'h00);
      run_one(4'd0,  4'd1,  2'd1, 1'b1, 1'b0, 4'd8, 8'hFF, 1'b0, 8'h00);

      // Forced wrong ALU result.
      force_zero = 1'b1;
      run_one(4'd1, 4'd1, 2'd0, 1'b0, 1'b0, 4'd9, 8'h00, CHK, CHK ? 8'h01 : 8'h00);
      force_zero = 1'b0;

      // Fill the FIFO with the consumer stalled.
      rsp_ready = 1'b0;
      got_tags.delete();
      for (int t = 0; t < 4; t++) begin
         drive_cmd(4'(t), 4'd1, 2'd0, 1'b0, 1'b0, 4'(t));
         wait_acc();
      end
      drive_cmd(4'd4, 4'd1, 2'd0, 1'b0, 1'b0, 4'd4);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("lit_full_cmd_ready", 32'(cmd_ready), 32'(0));
      end
      rsp_ready = 1'b1;
      wait_acc();
      cmd_valid = 1'b0;
      wait_tags(5);
      exp_tags = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      for (int i = 0; i < 5 && i < got_tags.size(); i++)
         check("lit_fill_order", 32'(got_tags[i]), 32'(exp_tags[i]));

      // Push and pop on the same edge at count 3, write pointer wraps.
      rsp_ready = 1'b0;
      got_tags.delete();
      for (int t = 8; t < 11; t++) begin
         drive_cmd(4'(t), 4'(t), 2'd2, 1'b0, 1'b0, 4'(t));
         wait_acc();
      end
      drive_cmd(4'd11, 4'd2, 2'd1, 1'b0, 1'b0, 4'd11);
      wait_acc();
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("lit_pushpop_cmd_ready", 32'(cmd_ready), 32'(1));
      check("lit_pushpop_head",      32'(rsp_tag),   32'(9));
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_tags(4);
      exp_tags = '{4'd8, 4'd9, 4'd10, 4'd11};
      for (int i = 0; i < 4 && i < got_tags.size(); i++)
         check("lit_wrap_order", 32'(got_tags[i]), 32'(exp_tags[i]));

      // Reset in EXEC with two entries queued.
      rsp_ready = 1'b0;
      got_tags.delete();
      drive_cmd(4'd1, 4'd2, 2'd0, 1'b0, 1'b0, 4'd1);
      wait_acc();
      drive_cmd(4'd3, 4'd4, 2'd0, 1'b0, 1'b0, 4'd2);
      wait_acc();
      drive_cmd(4'd5, 4'd6, 2'd2, 1'b0, 1'b0, 4'd6);
      wait_acc();
      cmd_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("lit_rst_rsp_valid", 32'(rsp_valid), 32'(0));
      check("lit_rst_busy",      32'(busy),      32'(0));
      check("lit_rst_alu_sel",   32'(alu_sel),   32'(ADD));
      check("lit_rst_alu_op1",   32'(alu_op1),   32'(0));
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      rsp_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("lit_rst_no_stale", 32'(got_tags.size()), 32'(0));
      run_one(4'd2, 4'd3, 2'd0, 1'b0, 1'b0, 4'd7, 8'h05, 1'b0, 8'h00);

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
